// File: rtl/slice_write_arbiter.sv
// slice_write_arbiter: round-robin arbitrated slice writes into a registered shadow vector, plus a one-slice-per-cycle clear sweep.
// Optional: define SLICE_WRITE_PARITY_EN to add slice_par, the per-slice even parity registered alongside vec_out.
module slice_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SLICE_W    = 24,
    parameter int NUM_SLICES = 64,
    parameter int IDX_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]      req_index,
    input  logic [NUM_REQ*SLICE_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          clr_req,
    output logic                          clr_done,
    output logic                          busy,
    output logic                          err_oor,
`ifdef SLICE_WRITE_PARITY_EN
    output logic [NUM_SLICES-1:0]         slice_par,
`endif
    output logic [NUM_SLICES*SLICE_W-1:0] vec_out
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int OFF_W = $clog2(NUM_SLICES*SLICE_W) + 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                        r_state, w_next;
    logic [PTR_W-1:0]              r_ptr, w_win, w_cand;
    logic [IDX_W-1:0]              r_cnt, w_idx, w_widx;
    logic [SLICE_W-1:0]            w_data, w_wdata;
    logic [OFF_W-1:0]              w_off;
    logic [NUM_SLICES*SLICE_W-1:0] r_vec;
    logic                          r_done, r_err;
    logic                          w_found, w_go, w_oor, w_last, w_we, w_clear;

    // Round-robin search: first valid requester upward from the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // A grant only happens in IDLE and loses to a coinciding clear request.
    assign w_clear   = (r_state == CLEAR);
    assign w_go      = rst_n && !w_clear && !clr_req && w_found;
    assign req_ready = w_go ? (NUM_REQ'(1) << w_win) : '0;
    assign w_idx     = req_index[w_win*IDX_W +: IDX_W];
    assign w_data    = req_data[w_win*SLICE_W +: SLICE_W];
    assign w_oor     = ({1'b0, w_idx} >= (IDX_W+1)'(NUM_SLICES));
    assign w_last    = (r_cnt == IDX_W'(NUM_SLICES - 1));

    // Single write port: the sweep zeroes slice r_cnt, otherwise the winner writes its slice.
    assign w_we    = w_clear || (w_go && !w_oor);
    assign w_widx  = w_clear ? r_cnt : w_idx;
    assign w_wdata = w_clear ? '0 : w_data;
    assign w_off   = OFF_W'(w_widx) * OFF_W'(SLICE_W);

    assign busy     = w_clear;
    assign clr_done = r_done;
    assign err_oor  = r_err;
    assign vec_out  = r_vec;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: clr_req starts a sweep from IDLE; the sweep ends on its last slice.
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (clr_req ? CLEAR : IDLE) : (w_last ? IDLE : CLEAR);
    end

    // Pointer advance on grant, sweep counter, done pulse and sticky out-of-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_clear && w_last;
            r_cnt  <= w_clear ? r_cnt + 1'b1 : '0;
            if (w_go)
                r_ptr <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            if (w_clear && w_last)
                r_err <= 1'b0;
            else if (w_go && w_oor)
                r_err <= 1'b1;
        end
    end

    // Shadow vector: one slice updated per write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_vec <= '0;
        else if (w_we) r_vec[w_off +: SLICE_W] <= w_wdata;
    end

`ifdef SLICE_WRITE_PARITY_EN
    logic [NUM_SLICES-1:0] r_par;

    // Per-slice parity tracks the data written on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_par <= '0;
        else if (w_we) r_par[w_widx] <= ^w_wdata;
    end

    assign slice_par = r_par;
`endif
endmodule

// File: tb/tb_slice_write_arbiter.sv
// tb_slice_write_arbiter: random and directed stimulus checked every cycle against a slice-array reference model.
module tb_slice_write_arbiter;
    localparam int NR = 4;
    localparam int SW = 24;
    localparam int NS = 40;
    localparam int IW = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr_req = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR*IW-1:0]     req_index = '0;
    logic [NR*SW-1:0]     req_data = '0;
    logic [NR-1:0]        req_ready;
    logic                 clr_done, busy, err_oor;
    logic [NS*SW-1:0]     vec_out;
`ifdef SLICE_WRITE_PARITY_EN
    logic [NS-1:0]        slice_par;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    slice_write_arbiter #(.NUM_REQ(NR), .SLICE_W(SW), .NUM_SLICES(NS), .IDX_W(IW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_index (req_index),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_req   (clr_req),
        .clr_done  (clr_done),
        .busy      (busy),
        .err_oor   (err_oor),
`ifdef SLICE_WRITE_PARITY_EN
        .slice_par (slice_par),
`endif
        .vec_out   (vec_out)
    );

    // Reference model: an array of slices, a rotating pointer and a sweep position.
    logic [SW-1:0] m_slice [NS];
    int            m_ptr, m_cnt, m_win;
    bit            m_busy, m_done, m_err;

    always_comb begin
        m_win = -1;
        if (!m_busy && !clr_req)
            for (int k = 0; k < NR; k++)
                if (m_win < 0 && ((req_valid >> ((m_ptr + k) % NR)) & 1) != 0)
                    m_win = (m_ptr + k) % NR;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) m_slice[k] <= '0;
            m_ptr  <= 0;
            m_cnt  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_slice[m_cnt] <= '0;
                m_cnt <= m_cnt + 1;
                if (m_cnt == NS - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_err  <= 1'b0;
                end
            end else if (clr_req) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
            end else if (m_win >= 0) begin
                m_ptr <= (m_win + 1) % NR;
                if (int'(req_index[m_win*IW +: IW]) < NS)
                    m_slice[int'(req_index[m_win*IW +: IW])] <= req_data[m_win*SW +: SW];
                else
                    m_err <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int first_bad();
        for (int k = 0; k < NS; k++) begin
            if (vec_out[k*SW +: SW] !== m_slice[k]) return k;
`ifdef SLICE_WRITE_PARITY_EN
            if (slice_par[k] !== ^m_slice[k]) return k;
`endif
        end
        return -1;
    endfunction

    // Every cycle out of reset: outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 64'(req_ready), (m_win < 0) ? 64'd0 : (64'd1 << m_win));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("clr_done", 64'(clr_done), 64'(m_done));
            chk("err_oor", 64'(err_oor), 64'(m_err));
            n_cmp++;
            if (first_bad() >= 0) begin
                n_err++;
                $display("FAIL vec slice %0d: got %0h expected %0h", first_bad(),
                         vec_out[first_bad()*SW +: SW], m_slice[first_bad()]);
            end
        end
    end

    task automatic do_write(input int r, input int idx, input logic [SW-1:0] d);
        int t = 0;
        req_index[r*IW +: IW] = IW'(idx);
        req_data[r*SW +: SW]  = d;
        req_valid[r] = 1'b1;
        @(negedge clk);
        while (!req_ready[r] && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL write grant timeout: requester %0d never saw ready", r);
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [NS*SW-1:0] mask;
    logic [NR-1:0]    rr_exp [5];
    logic [NR-1:0]    g;
    int               nb, nd;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset vec", 64'(|vec_out), 64'd0);
        chk("reset ready", 64'(req_ready), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset err", 64'(err_oor), 64'd0);
        chk("reset done", 64'(clr_done), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;

        req_index[0 +: IW] = 6'd5;
        req_data[0 +: SW]  = 24'hABCDEF;
        req_valid = 4'b0001;
        #1;
        chk("first ready", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        mask = '0;
        mask[143:120] = '1;
        chk("slice5 data", 64'(vec_out[143:120]), 64'hABCDEF);
        chk("other bits zero", 64'(|(vec_out & ~mask)), 64'd0);

        for (int r = 0; r < NR; r++) begin
            req_index[r*IW +: IW] = IW'(10 + r);
            req_data[r*SW +: SW]  = SW'($urandom);
        end
        req_valid = 4'b1000;
        #1;
        chk("rr from ptr1", 64'(req_ready), 64'b1000);
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr sequence", 64'(req_ready), 64'(rr_exp[i]));
            @(posedge clk);
            #1;
        end
        req_valid = 4'b1001;
        #1;
        chk("rr r3 before r0", 64'(req_ready), 64'b1000);
        @(posedge clk);
        #1;

        req_valid = 4'b0010;
        clr_req = 1'b1;
        #1;
        chk("clear beats request", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        nb = 0;
        nd = 0;
        for (int t = 0; t < 100 && busy; t++) begin
            nb++;
            @(posedge clk);
            #1;
            nd += int'(clr_done);
        end
        chk("sweep length", 64'(nb), 64'(NS));
        chk("done pulses", 64'(nd), 64'd1);
        chk("r1 after sweep", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("done one cycle", 64'(clr_done), 64'd0);

        do_write(2, 45, 24'h5A5A5A);
        chk("oor sets err", 64'(err_oor), 64'd1);
        do_write(0, 7, 24'h123456);
        chk("err sticky", 64'(err_oor), 64'd1);
        chk("slice7 data", 64'(vec_out[7*SW +: SW]), 64'h123456);

`ifdef SLICE_WRITE_PARITY_EN
        do_write(0, 3, 24'h000007);
        chk("parity odd", 64'(slice_par[3]), 64'd1);
        do_write(0, 3, 24'h000003);
        chk("parity even", 64'(slice_par[3]), 64'd0);
`endif

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
            clr_req = (c < 540) && ($urandom_range(59) == 0);
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r] && c < 540 && $urandom_range(1) == 1) begin
                    req_index[r*IW +: IW] = ($urandom_range(7) == 0) ? IW'($urandom_range(63, NS)) : IW'($urandom_range(NS - 1));
                    req_data[r*SW +: SW]  = SW'($urandom);
                    req_valid[r] = 1'b1;
                end
            end
        end
        req_valid = '0;
        clr_req = 1'b0;

        for (int k = 20; k < NS; k++) do_write(0, k, 24'h800000 | SW'(k));
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("slice20 before abort", 64'(vec_out[20*SW +: SW]), 64'h800014);
        chk("slice19 swept", 64'(vec_out[19*SW +: SW]), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort vec", 64'(|vec_out), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(clr_done), 64'd0);
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            nd += int'(clr_done);
        end
        rst_n = 1'b1;
        repeat (NS + 5) begin
            @(posedge clk);
            #1;
            nd += int'(clr_done);
        end
        chk("no done after abort", 64'(nd), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/slice_write_arbiter.md
Name: slice_write_arbiter

Overview:
- Owns a wide shadow vector of NUM_SLICES x SLICE_W bits (default 64 x 24 = 1536 bits).
- Shares slice-insert access among NUM_REQ requesters with round-robin arbitration, committing at most one slice write per clock.
- Provides a sequenced clear sweep that zeroes the vector one slice per cycle.
- Sits between configuration sources and the consumer of the 1536-bit vector; it replaces ad hoc combinational slice muxing with a registered, arbitrated write path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SLICE_W, 24, bits per slice.
- NUM_SLICES, 64, slices in the vector (<= 2**IDX_W).
- IDX_W, 6, slice index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_index  in  NUM_REQ*IDX_W  slice index; requester r occupies bits [r*IDX_W +: IDX_W].
- req_data  in  NUM_REQ*SLICE_W  slice payload; requester r occupies bits [r*SLICE_W +: SLICE_W].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready.
- clr_req  in  1  single-cycle pulse that starts the clear sweep.
- clr_done  out  1  one-cycle pulse when the sweep finishes.
- busy  out  1  high while the clear sweep runs.
- err_oor  out  1  sticky flag: an out-of-range index was accepted.
- vec_out  out  NUM_SLICES*SLICE_W  registered shadow vector; slice k = bits [k*SLICE_W +: SLICE_W].

Behaviour:
- Reset (async, rst_n=0):
  - vec_out=0, req_ready=0, clr_done=0, busy=0, err_oor=0.
  - RR pointer=0, sweep counter=0, state=IDLE.
  - Asserting reset during a sweep aborts it immediately; no clr_done is issued.
- States: IDLE, CLEAR.
- IDLE arbitration:
  - req_ready is combinational from req_valid and the RR pointer.
  - Winner = first r with req_valid[r]=1, searching upward from the pointer and wrapping modulo NUM_REQ.
  - Only the winner sees ready=1. No valid -> req_ready=0.
- Commit:
  - On a handshake edge, slice req_index of vec_out takes req_data.
  - The new value is visible on vec_out in the cycle after the handshake (latency 1). Other slices are unchanged.
  - Pointer becomes winner+1 mod NUM_REQ. With no grant, the pointer holds.
- Requester obligations: a requester holds valid, index and data stable until it sees ready. Losers wait, with no data loss.
- Out-of-range index (req_index >= NUM_SLICES):
  - The handshake still completes and the pointer advances.
  - No bits of vec_out change.
  - err_oor is set the next cycle.
- clr_req in IDLE:
  - The next state is CLEAR, with counter=0 and busy=1 from the next cycle.
  - If clr_req and any req_valid coincide, clear wins: req_ready=0 that cycle and no write occurs.
- CLEAR:
  - Each cycle, slice[counter] is set to 0 and counter increments.
  - req_ready=0 for all requesters; clr_req is ignored.
  - At counter=NUM_SLICES-1, that slice is zeroed and the block returns to IDLE. On the same edge, clr_done=1 for one cycle, busy=0 and err_oor=0.
  - The sweep takes exactly NUM_SLICES cycles from the first busy cycle. The RR pointer is preserved across the sweep.
- Width and arithmetic rules:
  - Slice offset = index*SLICE_W, computed in at least log2(NUM_SLICES*SLICE_W)+1 bits.
  - No truncation of the index product.

Optional Feature:
- SLICE_WRITE_PARITY_EN defined:
  - Adds output slice_par [NUM_SLICES], registered alongside vec_out.
  - slice_par[k] is the even parity (XOR) of slice k, updated on the same edge as the data.
  - slice_par resets to 0 and is 0 after a clear.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then write slice: req_valid=0001, index 5, data 0xABCDEF -> ready=0001 that cycle; next cycle vec_out[143:120]=0xABCDEF and all other bits 0.
- Round robin: all four requesters valid and held -> grants 0,1,2,3,0 on consecutive cycles. Then with the pointer at 1 and only r0 and r3 valid -> r3 is granted first.
- Clear collision: clr_req=1 with req_valid=0010 -> no ready. busy is high for 64 cycles, slices zero in ascending order, clr_done pulses once, then r1 is granted on the first IDLE cycle.
- Out-of-range, with NUM_SLICES=40: index 45 accepted -> vec_out unchanged and err_oor=1 next cycle. err_oor stays 1 until the end of a clear sweep.
- Async reset mid-sweep (counter=20, slices 20..63 nonzero) -> vec_out=0 immediately, busy=0, and no clr_done pulse.
- With SLICE_WRITE_PARITY_EN defined: write 0x000007 to slice 3 -> slice_par[3]=1 next cycle; then write 0x000003 -> slice_par[3]=0.
